strided_merge_sched: RTL and testbench
======================================

# strided_merge_sched

Scheduler that sequences a 16-input strided merge unit inside a Versat accelerator. It latches the stride, initial delay, input mask and round count on `run`, then waits out the delay. It walks the enabled inputs in ascending order, holding each select for `stride+1` cycles, and signals completion. It sits between the accelerator's run/running control and the merge datapath's input-select mux.

## Interface
- `DELAY_W`, 2: width of `stride` and `delay0`.
- `NUM_IN`, 16: number of merge inputs.
- `SEL_W`, 4: select width; must equal clog2(`NUM_IN`).
- `LEN_W`, 8: width of the round counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `run`  in  1  start pulse; sampled only in IDLE.
- `running`  in  1  accelerator-level enable; low aborts to IDLE.
- `stride`  in  DELAY_W  slot length minus one.
- `delay0`  in  DELAY_W  cycles between start and first slot.
- `in_mask`  in  NUM_IN  bit i set means input i participates.
- `rounds`  in  LEN_W  full sweeps to perform; 0 means sweep until `running` drops.
- `sel`  out  SEL_W  current input index, held for the whole slot.
- `sel_valid`  out  1  one-cycle pulse on the first cycle of each slot.
- `busy`  out  1  high in DELAY, SWEEP and DONE.
- `done`  out  1  one-cycle pulse after the final slot.

## Operation
- States: IDLE, DELAY, SWEEP, DONE.
- IDLE → DELAY when `run && running`.
  - Latch `stride`, `delay0`, `in_mask`, `rounds` into shadow registers.
  - Later input changes are ignored until the next IDLE.
- If the latched mask is all zeros, go IDLE → DONE directly. No `sel_valid` is issued.
- DELAY: down-counter loaded with `delay0`. If it is 0, fall through to SWEEP in the same cycle.
- SWEEP start: `sel` = lowest set mask bit, `sel_valid` = 1, slot counter = `stride`.
- SWEEP slot counting:
  - Slot counter decrements each cycle.
  - At 0, `sel` advances to the next set bit above the current one in the same cycle boundary. Unset bits are skipped in zero cycles (combinational priority search).
- Wrap: when no higher bit is set, `sel` wraps to the lowest set bit and the round counter increments.
- Termination: when the round counter reaches `rounds` (nonzero) at a wrap point, go to DONE instead of starting a new slot.
- DONE: `done` = 1 for one cycle, then → IDLE.
- Abort: `running` low in any non-IDLE state gives IDLE on the next edge.
  - `done` is not pulsed.
  - `sel_valid` is 0 from that edge on.
- `run` while busy is ignored.
- All outputs are registered. `sel` keeps its last value in IDLE.

## Timing
- Reset values: `sel`=0, `sel_valid`=0, `busy`=0, `done`=0, state=IDLE, all counters 0.
- Reset is asynchronous on assert and synchronous on release. Reset mid-operation clears everything immediately.
- Cycle 0: edge that samples `run`.
- Cycle 1+`delay0`: first `sel_valid`.
- Slot k starts at cycle 1+`delay0`+k·(`stride`+1).
- `done` is asserted the cycle after the last cycle of the last slot. Total length = 1+`delay0`+R·N·(`stride`+1), where N = popcount(mask) and R = `rounds`.
- Mask all-zero: `done` in cycle 1, `busy` high for that single cycle.
- `busy` rises in cycle 1 and falls the cycle after `done`.

## Configuration
- Macro `STRIDED_MERGE_SCHED_STALL_EN`.
- Defined:
  - Adds input `stall` (1 bit).
  - While `stall` is high, all counters and the state freeze and `sel_valid` is forced to 0.
  - A slot whose first cycle is stalled pulses `sel_valid` on the first unstalled cycle.
  - Abort via `running` still takes priority over `stall`.
- Undefined: no `stall` port; the scheduler never freezes.

## Test plan
- `stride`=3, `delay0`=3, `in_mask`=FFFF, `rounds`=1, run at cycle 0 → `sel_valid` at cycles 4,8,…,64 with `sel`=0..15; `done` at cycle 68; `busy` low at 69.
- `stride`=0, `delay0`=0, `in_mask`=8421, `rounds`=2 → `sel_valid` every cycle 1..8 with `sel`=0,5,10,15,0,5,10,15; `done` at 9.
- `in_mask`=0, any stride/delay → `done` at cycle 1, no `sel_valid`, `busy` high only at cycle 1.
- `rounds`=0, mask=0003, `stride`=1; drop `running` at cycle 10 → `sel` alternates 0/1 every 2 cycles until cycle 10; `busy`=0 and `sel_valid`=0 from 11; `done` never pulses.
- Assert `rst` low mid-SWEEP, between clock edges → `sel`, `sel_valid`, `busy`, `done` read 0 before the next edge. After release, a new `run` restarts cleanly. Change `stride` mid-sweep → no effect until the next run.
- With `STRIDED_MERGE_SCHED_STALL_EN`: `stride`=0, mask=000F, `stall` high in cycles 2–3 → `sel_valid` at cycles 1,4,5,6 with `sel`=0,1,2,3; `done` at 7.

Source files
------------

// File: rtl/strided_merge_sched.sv
// strided_merge_sched
// Sequences the input-select mux of a 16-input strided merge unit.
// The scheduler latches stride, initial delay, input mask and round count
// on a run pulse. It waits out the delay, then visits the enabled inputs in
// ascending order. Each select is held for stride+1 cycles. A done pulse
// follows the final slot of the final round.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (released synchronously)
//   run        start pulse, honoured only while idle
//   running    accelerator enable; dropping it aborts to idle
//   stall      (STRIDED_MERGE_SCHED_STALL_EN only) freezes the scheduler
//   stride     slot length minus one
//   delay0     cycles between start and first slot
//   in_mask    bit i set means input i takes part in the sweep
//   rounds     number of full sweeps, 0 = sweep until running drops
//   sel        current input index, held for the whole slot
//   sel_valid  one-cycle pulse on the first cycle of each slot
//   busy       high while a schedule is in progress
//   done       one-cycle pulse after the last slot
//
// Optional feature: define STRIDED_MERGE_SCHED_STALL_EN to add the stall input.
// All outputs are registered. A given output therefore reflects the decision
// made at the clock edge that produced it.

module strided_merge_sched #(
  parameter int DELAY_W = 2,
  parameter int NUM_IN  = 16,
  parameter int SEL_W   = 4,
  parameter int LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
`ifdef STRIDED_MERGE_SCHED_STALL_EN
  input  logic               stall,
`endif
  input  logic [DELAY_W-1:0] stride,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [NUM_IN-1:0]  in_mask,
  input  logic [LEN_W-1:0]   rounds,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [DELAY_W-1:0] DLY_ONE   = DELAY_W'(1);
  localparam logic [LEN_W-1:0]   ROUND_ONE = LEN_W'(1);

  // Lowest set bit of the mask (priority search, zero cycles).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_IN-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [SEL_W:0] next_above(input logic [NUM_IN-1:0] m,
                                                input logic [SEL_W-1:0]  cur);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic               rst_n_s;
  logic               stall_s;

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] stride_q, stride_d;
  logic [NUM_IN-1:0]  mask_q, mask_d;
  logic [LEN_W-1:0]   rounds_q, rounds_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [DELAY_W-1:0] slot_q, slot_d;
  logic [LEN_W-1:0]   round_q, round_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SEL_W-1:0]   first_s;
  logic [SEL_W:0]     next_s;
  logic [LEN_W-1:0]   round_inc_s;

`ifdef STRIDED_MERGE_SCHED_STALL_EN
  assign stall_s = stall;
`else
  assign stall_s = 1'b0;
`endif

  // Reset release is re-timed to the clock; assertion still acts at once.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchroniser flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= rst_sync_d;
  end

  assign rst_n_s = rst_sync_q[1];

  assign first_s     = lowest_set(mask_q);
  assign next_s      = next_above(mask_q, sel_q);
  assign round_inc_s = round_q + ROUND_ONE;

  // Next-state and registered-output decisions.
  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    mask_d      = mask_q;
    rounds_d    = rounds_q;
    dly_d       = dly_q;
    slot_d      = slot_q;
    round_d     = round_q;
    sel_d       = sel_q;
    sel_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (state_q == S_IDLE) begin
      busy_d = 1'b0;
      // busy_q still high here means the done pulse was just shown; a run
      // in that cycle arrives while busy and is dropped.
      if (run && running && !busy_q) begin
        stride_d = stride;
        mask_d   = in_mask;
        rounds_d = rounds;
        dly_d    = delay0;
        slot_d   = '0;
        round_d  = '0;
        state_d  = (in_mask == '0) ? S_DONE : S_DELAY;
      end else begin
        state_d = S_IDLE;
      end
    end else if (!running) begin
      // Abort beats stall and suppresses done.
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else if (stall_s) begin
      // Frozen: the postponed action (including a slot start) runs later.
      state_d = state_q;
    end else begin
      busy_d = 1'b1;
      case (state_q)
        S_DELAY: begin
          if (dly_q != '0) begin
            dly_d = dly_q - DLY_ONE;
          end else begin
            state_d     = S_SWEEP;
            sel_d       = first_s;
            sel_valid_d = 1'b1;
            slot_d      = stride_q;
          end
        end
        S_SWEEP: begin
          if (slot_q != '0) begin
            slot_d = slot_q - DLY_ONE;
          end else if (next_s[SEL_W]) begin
            sel_d       = next_s[SEL_W-1:0];
            sel_valid_d = 1'b1;
            slot_d      = stride_q;
          end else if ((rounds_q != '0) && (round_inc_s == rounds_q)) begin
            // Last slot of the last round has ended: pulse done now.
            round_d = round_inc_s;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            round_d     = round_inc_s;
            sel_d       = first_s;
            sel_valid_d = 1'b1;
            slot_d      = stride_q;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, shadow, counter and output registers.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q     <= S_IDLE;
      stride_q    <= '0;
      mask_q      <= '0;
      rounds_q    <= '0;
      dly_q       <= '0;
      slot_q      <= '0;
      round_q     <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      mask_q      <= mask_d;
      rounds_q    <= rounds_d;
      dly_q       <= dly_d;
      slot_q      <= slot_d;
      round_q     <= round_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_strided_merge_sched.sv
module tb_strided_merge_sched;

  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        running;
  logic [1:0]  stride;
  logic [1:0]  delay0;
  logic [15:0] in_mask;
  logic [7:0]  rounds;
  logic [3:0]  sel;
  logic        sel_valid;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  prev_sel = 4'd0;

  always #5 clk = ~clk;

  strided_merge_sched dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .running  (running),
    .stride   (stride),
    .delay0   (delay0),
    .in_mask  (in_mask),
    .rounds   (rounds),
    .sel      (sel),
    .sel_valid(sel_valid),
    .busy     (busy),
    .done     (done)
  );

  // Runs one schedule and compares every cycle against the timing formulas:
  // slot k starts at 1+delay0+k*(stride+1), select = k-th enabled input
  // (mod popcount), done at 1+delay0+R*N*(stride+1). running is dropped
  // after cycle abort_c is observed.
  task automatic test_schedule(input string name, input logic [1:0] st,
                               input logic [1:0] dl, input logic [15:0] m,
                               input logic [7:0] rd, input int abort_c);
    int en[16];
    int n, len, start, total, stop, ncyc, cs;
    logic ev, eb, ed, live;
    logic [3:0] es;
    n = 0;
    for (int i = 0; i < 16; i++) if (m[i]) begin en[n] = i; n++; end
    len   = int'(st) + 1;
    start = 1 + int'(dl);
    if (n == 0)       total = 1;
    else if (rd == 0) total = NEVER;
    else              total = start + int'(rd) * n * len;
    stop = (total < abort_c) ? total : abort_c;
    ncyc = stop + 3;
    es   = prev_sel;

    @(negedge clk);
    stride = st; delay0 = dl; in_mask = m; rounds = rd;
    run = 1'b1; running = 1'b1;
    @(posedge clk);  // cycle 0
    for (int c = 1; c <= ncyc; c++) begin
      #1;
      // Scramble inputs: none may matter until the next run.
      stride  = 2'($urandom);
      delay0  = 2'($urandom);
      in_mask = 16'($urandom);
      rounds  = 8'($urandom);
      run     = (c < stop) ? 1'($urandom) : 1'b0;
      @(posedge clk);
      #1;
      live = (c <= abort_c);
      eb = live && (c <= total);
      ed = live && (c == total);
      ev = live && (n > 0) && (c >= start) && (c < total) && (((c - start) % len) == 0);
      cs = (c < abort_c) ? c : abort_c;
      if (cs > total - 1) cs = total - 1;
      es = (n > 0 && cs >= start) ? 4'(en[((cs - start) / len) % n]) : prev_sel;
      checks++;
      if (sel_valid !== ev) begin
        errors++;
        $display("FAIL %s sel_valid cycle %0d: got %b expected %b", name, c, sel_valid, ev);
      end
      checks++;
      if (sel !== es) begin
        errors++;
        $display("FAIL %s sel cycle %0d: got %0d expected %0d", name, c, sel, es);
      end
      checks++;
      if (busy !== eb) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, eb);
      end
      checks++;
      if (done !== ed) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b expected %b", name, c, done, ed);
      end
      if (c == abort_c) running = 1'b0;
    end
    prev_sel = es;
    run = 1'b0;
    running = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; running = 1'b1;
    stride = 2'd0; delay0 = 2'd0; in_mask = 16'h0000; rounds = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sel, sel_valid, busy, done} !== 7'd0) begin
      errors++;
      $display("FAIL reset outputs: got %b expected 0000000", {sel, sel_valid, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    prev_sel = 4'd0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    stride = 2'd3; delay0 = 2'd0; in_mask = 16'hFFFF; rounds = 8'd2;
    run = 1'b1; running = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (21) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sel, sel_valid, busy, done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %b expected 0000000", {sel, sel_valid, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    prev_sel = 4'd0;
    test_schedule("after_reset", 2'd1, 2'd2, 16'h0C30, 8'd1, NEVER);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      logic [15:0] m;
      logic [7:0]  rd;
      int          ab;
      m  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      rd = 8'($urandom_range(0, 3));
      if (rd == 8'd0)                     ab = $urandom_range(1, 40);
      else if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, 30);
      else                                ab = NEVER;
      test_schedule("random", 2'($urandom), 2'($urandom), m, rd, ab);
    end
  endtask

  initial begin
    test_reset();
    test_schedule("full_sweep", 2'd3, 2'd3, 16'hFFFF, 8'd1, NEVER);
    test_schedule("stride0_two_rounds", 2'd0, 2'd0, 16'h8421, 8'd2, NEVER);
    test_schedule("empty_mask", 2'd2, 2'd3, 16'h0000, 8'd1, NEVER);
    test_schedule("abort_endless", 2'd1, 2'd0, 16'h0003, 8'd0, 10);
    test_schedule("back_to_back", 2'd0, 2'd1, 16'h8001, 8'd3, NEVER);
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
